add_seq_n: RTL
==============

// Module: add_seq_n
// PURPOSE
//   Parametrised multi-cycle adder/subtractor. Adds two WIDTH-bit operands
//   CHUNK bits per clock, with the carry held in a register between chunks.
//   Uses a start/busy/done handshake.
//   Shares the datapath fabric with the fixed-width ripple adders. Used where
//   operand width exceeds what one cycle of carry ripple can close.
//   Adds subtract mode, a signed-overflow flag and registered result outputs.
// PARAMETERS
//   WIDTH   32   operand/result width in bits
//   CHUNK   4    bits processed per cycle. WIDTH % CHUNK == 0 and CHUNK >= 1
//                are required; violation is an elaboration error.
//   (derived) NCHUNK = WIDTH/CHUNK, the number of RUN cycles per operation
// PORTS
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous reset, active-high
//   start  in   1      request; sampled only in IDLE
//   sub    in   1      0: a+b+cin   1: a-b (a + ~b + 1, cin ignored)
//   a      in   WIDTH  operand A, captured when start is accepted
//   b      in   WIDTH  operand B, captured when start is accepted
//   cin    in   1      carry-in for add mode, captured with operands
//   busy   out  1      1 while in RUN
//   done   out  1      one-cycle pulse: result valid and updated
//   sum    out  WIDTH  result, registered
//   cout   out  1      carry out of MSB. In sub mode 1 = no borrow.
//   ovf    out  1      two's-complement overflow: carry into MSB ^ carry out of MSB
// BEHAVIOUR
//   Reset
//     Asynchronous while rst=1: state=IDLE, all outputs 0, internal
//     shift/carry/counter registers 0.
//   States
//     IDLE --start--> RUN. RUN stays for NCHUNK cycles, then returns to IDLE.
//   Accept (IDLE && start at edge E0)
//     - latch a_sh=a, b_sh = sub ? ~b : b, carry = sub ? 1 : cin, cnt=0
//     - busy=1 after E0
//   RUN, each edge E1..E_NCHUNK
//     - compute {c, s} = a_sh[CHUNK-1:0] + b_sh[CHUNK-1:0] + carry
//     - s shifts into the top of the result shift register
//     - a_sh and b_sh shift right by CHUNK
//     - carry=c; cnt++
//   Final chunk (cnt == NCHUNK-1)
//     - on the same edge E_NCHUNK: sum <= full result, cout <= c,
//       ovf <= carry-into-MSB ^ c, done <= 1, busy <= 0, state <= IDLE
//     - done clears at the next edge
//   Timing and throughput
//     - latency: done is high in the cycle after edge E0+NCHUNK
//     - a start sampled during the done cycle is accepted (edge E0+NCHUNK+1)
//     - maximum throughput is one operation per NCHUNK+1 cycles
//   Result hold
//     - sum/cout/ovf hold their value from one done to the next; they are
//       not cleared by a new start
//     - a, b, cin and sub may change freely after acceptance
//   Start while busy
//     - ignored; no queueing; in-flight operation unaffected
//   Reset mid-operation
//     - operation aborted; no done is produced after rst is released
//     - outputs read 0 until the next completion
//   Degenerate CHUNK==WIDTH
//     - single RUN cycle; done after edge E0+1
//   Width rules
//     - all arithmetic is modulo 2^WIDTH
//     - chunk adder is CHUNK+1 bits
//     - ovf uses bit WIDTH-1 of the final chunk
// TESTING (WIDTH=32, CHUNK=4 unless noted)
//   1. add a=FFFFFFFF b=1 cin=0 -> sum=0 cout=1 ovf=0; done exactly 8 cycles
//      after start edge, busy high for those 8 cycles
//   2. sub a=5 b=7 -> sum=FFFFFFFE cout=0 ovf=0; sub a=7 b=5 -> sum=2 cout=1
//   3. add a=7FFFFFFF b=1 cin=0 -> sum=80000000 ovf=1 cout=0; add a=80000000
//      b=80000000 -> sum=0 cout=1 ovf=1
//   4. start pulsed on cycles 3 and 5 while busy -> ignored, single done.
//      start held high -> done pulses every 9 cycles, each result correct.
//   5. rst asserted after 3 RUN cycles -> busy/done/sum/cout/ovf 0
//      immediately (no clock); after release no done until a new start
//   6. CHUNK=WIDTH=16 and CHUNK=1,WIDTH=8 builds
//      - 1000 random a/b/cin/sub vs model {cout,sum}=a+(sub?~b:b)+(sub?1:cin)
//      - exact done latency NCHUNK cycles after the start edge

Source files
------------

// File: rtl/add_seq_n.sv
`default_nettype none
// ============================================================================
// Module  : add_seq_n
// Brief   : Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock,
//           with start/busy/done handshake and registered sum/cout/ovf.
// Revision: 1.0 - initial release
// ============================================================================
module add_seq_n #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [CW-1:0] c_last_cnt = CW'(NCHUNK - 1);
  localparam logic [0:0]    c_idle     = 1'b0;
  localparam logic [0:0]    c_run      = 1'b1;

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("add_seq_n: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [CHUNK:0]         w_chunk;
  logic                   w_msb_cin;
  logic [WIDTH+CHUNK-1:0] w_cat;
  logic [WIDTH-1:0]       w_res_next;

  assign w_chunk = {1'b0, r_a_sh[CHUNK-1:0]} + {1'b0, r_b_sh[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, r_carry};

  // On the last chunk, bit CHUNK-1 of the chunk is result bit WIDTH-1;
  // recover the carry into it from the sum bit and its two addend bits.
  assign w_msb_cin  = r_a_sh[CHUNK-1] ^ r_b_sh[CHUNK-1] ^ w_chunk[CHUNK-1];

  assign w_cat      = {w_chunk[CHUNK-1:0], r_res_sh};
  assign w_res_next = WIDTH'(w_cat >> CHUNK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_idle;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        c_idle: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= c_run;
          end
        end
        c_run: begin
          r_res_sh <= w_res_next;
          r_a_sh   <= r_a_sh >> CHUNK;
          r_b_sh   <= r_b_sh >> CHUNK;
          r_carry  <= w_chunk[CHUNK];
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == c_last_cnt) begin
            sum     <= w_res_next;
            cout    <= w_chunk[CHUNK];
            ovf     <= w_msb_cin ^ w_chunk[CHUNK];
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= c_idle;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
